// File: rtl/handshake_pkg.sv
// handshake_pkg: shared defaults (widths, EXPECTED constant) and a saturating-increment helper for handshake units
package handshake_pkg;
  localparam int DATA_WIDTH_D = 32;
  localparam int COUNT_WIDTH_D = 16;
  localparam logic [31:0] EXPECTED_D = 32'd30;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v == max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/handshake_oehb_ctrl.sv
// handshake_oehb_ctrl: dataless one-slot output-registered buffer; ports clk, rst, ins_valid/ins_ready in, outs_valid/outs_ready out
module handshake_oehb_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic ins_valid,
  output logic ins_ready,
  output logic outs_valid,
  input  logic outs_ready
);
  assign ins_ready = ~outs_valid | outs_ready;
  always_ff @(posedge clk)
    if (rst) outs_valid <= 1'b0;
    else outs_valid <= (ins_valid & ins_ready) | (outs_valid & ~outs_ready);
endmodule

// File: rtl/handshake_constant_check.sv
// handshake_constant_check: consumes ins tokens, emits one control token each via oehb slot; with HANDSHAKE_CONST_CHECK_STATS_EN reports sticky mismatch, first bad value, saturating token_count
module handshake_constant_check
  import handshake_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter logic [DATA_WIDTH-1:0] EXPECTED = DATA_WIDTH'(EXPECTED_D),
  parameter int COUNT_WIDTH = COUNT_WIDTH_D
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic                   outs_valid,
  input  logic                   outs_ready,
  output logic                   mismatch,
  output logic [DATA_WIDTH-1:0]  mismatch_data,
  output logic [COUNT_WIDTH-1:0] token_count
);
  handshake_oehb_ctrl u_oehb (
    .clk(clk),
    .rst(rst),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );
`ifdef HANDSHAKE_CONST_CHECK_STATS_EN
  logic acc;
  assign acc = ins_valid & ins_ready;
  always_ff @(posedge clk)
    if (rst) begin
      mismatch <= 1'b0;
      mismatch_data <= '0;
      token_count <= '0;
    end else if (acc) begin
      if (ins != EXPECTED && !mismatch) begin
        mismatch <= 1'b1;
        mismatch_data <= ins;
      end
      token_count <= COUNT_WIDTH'(sat_inc(32'(token_count), 32'({COUNT_WIDTH{1'b1}})));
    end
`else
  logic unused_ins;
  assign unused_ins = ^ins;
  assign mismatch = 1'b0;
  assign mismatch_data = '0;
  assign token_count = '0;
`endif
endmodule

// File: tb/tb_handshake_constant_check.sv
// tb_handshake_constant_check: randomized self-checking bench against a token-count reference model
module tb_handshake_constant_check;
  localparam int DW = 32;
  localparam int CW = 4;
`ifdef HANDSHAKE_CONST_CHECK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DW-1:0] ins = '0;
  logic ins_valid = 1'b0;
  logic ins_ready;
  logic outs_valid;
  logic outs_ready = 1'b0;
  logic mismatch;
  logic [DW-1:0] mismatch_data;
  logic [CW-1:0] token_count;
  int checks = 0;
  int failures = 0;
  int acc_n = 0;
  int fire_n = 0;
  bit mm_m = 0;
  logic [DW-1:0] mmd_m = '0;
  handshake_constant_check #(.DATA_WIDTH(DW), .EXPECTED(32'd30), .COUNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst(rst),
    .ins(ins),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready),
    .mismatch(mismatch),
    .mismatch_data(mismatch_data),
    .token_count(token_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    bit pend, rdy, acc;
    @(negedge clk);
    ins_valid = v;
    ins = d;
    outs_ready = r;
    #1;
    pend = (acc_n > fire_n);
    rdy = !pend || r;
    chk("outs_valid", 32'(outs_valid), 32'(pend));
    chk("ins_ready", 32'(ins_ready), 32'(rdy));
    chk("mismatch", 32'(mismatch), STATS ? 32'(mm_m) : 32'd0);
    chk("mismatch_data", mismatch_data, STATS ? mmd_m : 32'd0);
    chk("token_count", 32'(token_count), STATS ? ((acc_n > 15) ? 32'd15 : 32'(acc_n)) : 32'd0);
    acc = v && rdy;
    @(posedge clk);
    if (pend && r) fire_n++;
    if (acc) begin
      acc_n++;
      if (d != 32'd30 && !mm_m) begin
        mm_m = 1;
        mmd_m = d;
      end
    end
    if (acc_n - fire_n > 1 || fire_n > acc_n) begin
      failures++;
      $display("FAIL model_occupancy acc=%0d fire=%0d", acc_n, fire_n);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ins_valid = 1'($urandom);
    outs_ready = 1'($urandom);
    ins = $urandom;
    @(posedge clk);
    acc_n = 0;
    fire_n = 0;
    mm_m = 0;
    mmd_m = '0;
    #1 rst = 1'b0;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 30, 1);
    step(0, 30, 1);
    step(0, 30, 1);
    step(1, 30, 0);
    for (int i = 0; i < 3; i++) step(1, 30, 0);
    step(1, 30, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    do_reset();
    step(1, 30, 1);
    step(1, 7, 1);
    step(1, 30, 1);
    step(1, 9, 1);
    step(0, 9, 1);
    step(0, 9, 1);
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 30, 1);
    step(0, 0, 1);
    step(1, 30, 0);
    step(1, 30, 0);
    do_reset();
    step(1, 30, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 60) == 0) do_reset();
      step(1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom : 32'd30, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/handshake_constant_check.md
# handshake_constant_check

Dataless-result consumer for a constant-valued handshake channel: accepts tokens on a data channel, checks each against a compile-time expected constant, and emits one control (dataless) token per accepted input through a one-slot registered buffer. It is the receiving end of a constant source and sits between a constant-producing handshake unit and downstream join/control logic. It also reports a sticky mismatch flag, the first offending value, and an accepted-token count for debug and verification.

## Interface
- DATA_WIDTH, 32, width of `ins`
- EXPECTED, 30 (6'b011110 zero-extended), value every token must carry
- COUNT_WIDTH, 16, width of `token_count`

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ins  input  DATA_WIDTH  input channel data
- ins_valid  input  1  input channel valid
- ins_ready  output  1  input channel ready
- outs_valid  output  1  control output channel valid, registered
- outs_ready  input  1  control output channel ready
- mismatch  output  1  sticky: some accepted token differed from EXPECTED
- mismatch_data  output  DATA_WIDTH  value of first mismatching token
- token_count  output  COUNT_WIDTH  accepted-token count, saturating

## Operation
- Input accept: `acc = ins_valid & ins_ready`; output fire: `fire = outs_valid & outs_ready`.
- `ins_ready = ~outs_valid | outs_ready` (combinational; one slot, full throughput).
- Slot register `outs_valid`: set on `acc`; cleared on `fire & ~acc`; held otherwise. `acc & fire` in the same cycle keeps it at 1.
- Check: on `acc`, if `ins != EXPECTED` and `mismatch == 0` -> `mismatch <= 1`, `mismatch_data <= ins`. Later mismatches do not overwrite. Cleared only by `rst`.
- Counter: on `acc`, `token_count <= token_count + 1` unless all ones (saturates, no wrap).
- Tokens are never dropped or duplicated: each `acc` produces exactly one `fire`, in order.
- `ins` is sampled only when `acc`; its value while `ins_valid = 0` is ignored.

## Timing
- Reset values: `outs_valid = 0`, `mismatch = 0`, `mismatch_data = 0`, `token_count = 0`; `ins_ready = 1` in the first cycle after reset.
- Latency: token accepted in cycle N -> `outs_valid = 1` in N+1.
- Throughput: one token/cycle while `outs_ready = 1`.
- Full slot with `outs_ready = 0` -> `ins_ready = 0`; `ins_ready` depends combinationally on `outs_ready` only.
- `outs_valid` once asserted stays asserted until `fire`.
- `rst` mid-operation: buffered token discarded, all state to reset values next edge, regardless of handshake inputs that cycle.
- `mismatch`, `mismatch_data`, `token_count` update one edge after the accepting cycle.

## Configuration
- `HANDSHAKE_CONST_CHECK_STATS_EN` defined: mismatch detection, `mismatch_data` capture, and `token_count` as described.
- Not defined: no compare or counter logic; `mismatch`, `mismatch_data`, `token_count` tied to 0. Handshake behaviour identical in both builds.

## Structure
- Shared package `handshake_pkg`: default `EXPECTED` constant, default widths, and a saturating-increment function for counters.
- One sub-module: `handshake_oehb_ctrl` — dataless one-slot output-registered buffer (`ins_valid/ins_ready` -> `outs_valid/outs_ready`), reused by other control-only units. Top instantiates it and adds the check/count logic.

## Test plan
- Reset then stream 5 tokens `ins = 30`, `outs_ready = 1` constantly -> `outs_valid` high cycles 2..6 relative to first accept at cycle 1, `ins_ready` always 1, `token_count = 5`, `mismatch = 0`.
- Backpressure: one token accepted, `outs_ready = 0` for 3 cycles while `ins_valid = 1` -> `ins_ready = 0` those cycles, `outs_valid` held 1, no count increase; on `outs_ready = 1` simultaneous fire+accept keeps `outs_valid = 1`.
- Mismatch: tokens 30, 7, 30, 9 -> `mismatch = 1` from the edge after token 7, `mismatch_data = 7` (not 9), `token_count = 4`.
- Saturation with COUNT_WIDTH = 4: 20 tokens -> `token_count` stops at 15, no wrap to 0.
- Reset mid-operation: token buffered with `outs_ready = 0`, assert `rst` one cycle -> next cycle `outs_valid = 0`, `mismatch = 0`, `token_count = 0`, `ins_ready = 1`.
- Build without `HANDSHAKE_CONST_CHECK_STATS_EN`: rerun mismatch scenario -> identical handshake trace, `mismatch`, `mismatch_data`, `token_count` all 0.
